// File: rtl/req_queue_bank.sv
// rtl/req_queue_bank.sv - four independent request FIFOs feeding a 4-input priority/round-robin mux
module req_queue_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          wr_valid,
  input  logic [4*DATA_W-1:0] wr_data,
  output logic [3:0]          wr_ready,
  input  logic [3:0]          flush,
  input  logic [3:0]          grant,
  output logic [3:0]          req,
  output logic [4*DATA_W-1:0] data_in,
  output logic [4*CW-1:0]     occupancy,
  output logic [3:0]          err_underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Holds wr_ready low during reset and until the first clock edge after release.
  logic live;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  for (genvar i = 0; i < 4; i++) begin : g_ch
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wp;
    logic [AW-1:0]     rp;
    logic [CW-1:0]     cnt;
    logic              err_q;
    logic              push;
    logic              pop;

    // Ready ignores grant so a full channel never accepts on the cycle it drains.
    assign wr_ready[i] = live && (cnt != FULL) && !flush[i];
    assign push        = wr_valid[i] && wr_ready[i];
    assign pop         = grant[i] && (cnt != '0) && !flush[i];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wp    <= '0;
        rp    <= '0;
        cnt   <= '0;
        err_q <= 1'b0;
      end else if (flush[i]) begin
        wp  <= '0;
        rp  <= '0;
        cnt <= '0;
      end else begin
        if (push) wp <= wp + 1'b1;
        if (pop)  rp <= rp + 1'b1;
        if (push && !pop)      cnt <= cnt + 1'b1;
        else if (pop && !push) cnt <= cnt - 1'b1;
        if (grant[i] && (cnt == '0)) err_q <= 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (push) mem[wp] <= wr_data[i*DATA_W +: DATA_W];
    end

    // Request side is driven only from registered state; the mux closes grant on req.
    assign req[i]                         = (cnt != '0);
    assign data_in[i*DATA_W +: DATA_W]    = (cnt != '0) ? mem[rp] : '0;
    assign occupancy[i*CW +: CW]          = cnt;
    assign err_underflow[i]               = err_q;
  end

endmodule
